// File: rtl/timer_pkg.sv
// timer_pkg: shared widths, standard moduli and load clamp for cascaded down-timers
package timer_pkg;
  localparam int DEFAULT_DIGIT_W = 4;
  localparam logic [15:0] MODULI_MMSS = 16'h5959;
  localparam logic [19:0] MODULI_HMMSS = 20'h95959;
  function automatic int unsigned clamp(input int unsigned v, input int unsigned m);
    return v > m ? m : v;
  endfunction
endpackage

// File: rtl/down_digit.sv
// down_digit: one down-counting digit; clamps on load, wraps to MAX on borrow from 0
// ports: clk, clr (sync reset), load/load_value, borrow_in (decrement), wrap_all (force MAX), value, is_zero
module down_digit
  import timer_pkg::*;
#(
  parameter int MAX = 9,
  parameter int W = DEFAULT_DIGIT_W
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         borrow_in,
  input  logic         wrap_all,
  output logic [W-1:0] value,
  output logic         is_zero
);
  localparam logic [W-1:0] M = W'(MAX);
  if (MAX < 1 || MAX > (1 << W) - 1) begin : g_bad_max
    $fatal(1, "down_digit: MAX %0d does not fit 1..2^%0d-1", MAX, W);
  end
  assign is_zero = value == '0;
  always_ff @(posedge clk)
    if (clr) value <= '0;
    else if (load) value <= W'(clamp(32'(load_value), 32'(MAX)));
    else if (wrap_all) value <= M;
    else if (borrow_in) value <= is_zero ? M : value - 1'b1;
endmodule

// File: rtl/down_timer_cascade.sv
// down_timer_cascade: N-digit mixed-radix down-counter with clamp, saturate/wrap at zero and done pulse
// ports: clk, clr (sync reset), data/loadn (active-low load), en (tick), out, tc (per-digit borrow-out), zero, done
module down_timer_cascade
  import timer_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W = DEFAULT_DIGIT_W,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0] MODULI = MODULI_MMSS,
  parameter bit STOP_AT_ZERO = 1'b1
) (
  input  logic                          clk,
  input  logic                          clr,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] data,
  input  logic                          loadn,
  input  logic                          en,
  output logic [NUM_DIGITS*DIGIT_W-1:0] out,
  output logic [NUM_DIGITS-1:0]         tc,
  output logic                          zero,
  output logic                          done
);
  localparam int TW = NUM_DIGITS * DIGIT_W;
  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_n
    $fatal(1, "down_timer_cascade: NUM_DIGITS %0d outside 1..8", NUM_DIGITS);
  end
  logic [NUM_DIGITS-1:0] is_zero;
  logic all_zero, one_left, counting, wrap_all;
  assign all_zero = &is_zero;
  // a decrement lands on zero only from exactly 1, since borrowing digits wrap to a nonzero max
  assign one_left = out == TW'(1);
  assign counting = loadn & en & ~all_zero;
  assign wrap_all = loadn & en & all_zero & ~STOP_AT_ZERO;
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    localparam logic [NUM_DIGITS-1:0] BELOW = NUM_DIGITS'((1 << i) - 1);
    localparam logic [NUM_DIGITS-1:0] UPTO = NUM_DIGITS'((1 << (i + 1)) - 1);
    assign tc[i] = en & (&(is_zero | ~UPTO));
    down_digit #(
      .MAX(int'(MODULI[i*DIGIT_W +: DIGIT_W])),
      .W  (DIGIT_W)
    ) u_digit (
      .clk       (clk),
      .clr       (clr),
      .load      (~loadn),
      .load_value(data[i*DIGIT_W +: DIGIT_W]),
      .borrow_in (counting & (&(is_zero | ~BELOW))),
      .wrap_all  (wrap_all),
      .value     (out[i*DIGIT_W +: DIGIT_W]),
      .is_zero   (is_zero[i])
    );
  end
  // clamped load is zero exactly when data is zero, because every modulus is at least 1
  always_ff @(posedge clk)
    if (clr) begin
      zero <= 1'b1;
      done <= 1'b0;
    end else if (!loadn) begin
      zero <= ~|data;
      done <= 1'b0;
    end else if (en) begin
      zero <= all_zero ? STOP_AT_ZERO : one_left;
      done <= ~all_zero & one_left;
    end else done <= 1'b0;
endmodule

// File: tb/tb_down_timer_cascade.sv
// tb_down_timer_cascade: directed scoreboard bench for saturating and wrapping timer variants
module tb_down_timer_cascade;
  typedef struct {
    string tag;
    logic [15:0] out;
    logic zero;
    logic done;
  } exp_t;
  logic clk = 1'b0;
  logic clr = 1'b0;
  logic loadn = 1'b1;
  logic en = 1'b0;
  logic [15:0] data = '0;
  logic [15:0] out, out_w;
  logic [3:0] tc, tc_w;
  logic zero, done, zero_w, done_w;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  down_timer_cascade dut (
    .clk(clk), .clr(clr), .data(data), .loadn(loadn), .en(en),
    .out(out), .tc(tc), .zero(zero), .done(done)
  );
  down_timer_cascade #(.STOP_AT_ZERO(1'b0)) dut_w (
    .clk(clk), .clr(clr), .data(data), .loadn(loadn), .en(en),
    .out(out_w), .tc(tc_w), .zero(zero_w), .done(done_w)
  );
  task automatic cmp(input string tag, input logic [15:0] got, input logic [15:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask
  task automatic pop_check();
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard: observed empty queue expected entry");
    end else begin
      e = q.pop_front();
      cmp({e.tag, ".out"}, out, e.out);
      cmp({e.tag, ".zero"}, 16'(zero), 16'(e.zero));
      cmp({e.tag, ".done"}, 16'(done), 16'(e.done));
    end
  endtask
  task automatic step(input string tag, input logic c, input logic ln, input logic e, input logic [15:0] d,
                      input logic [15:0] eo, input logic ez, input logic ed,
                      input bit ctc, input logic [3:0] etc);
    clr = c;
    loadn = ln;
    en = e;
    data = d;
    q.push_back('{tag, eo, ez, ed});
    #1;
    if (ctc) cmp({tag, ".tc"}, 16'(tc), 16'(etc));
    @(posedge clk);
    #1;
    pop_check();
  endtask
  initial begin
    @(posedge clk);
    #1;
    step("reset", 1, 1, 0, 16'h0000, 16'h0000, 1, 0, 0, 4'h0);
    step("hold_zero", 0, 1, 1, 16'h0000, 16'h0000, 1, 0, 1, 4'b1111);
    cmp("wrap.out", out_w, 16'h5959);
    cmp("wrap.zero", 16'(zero_w), 16'h0000);
    cmp("wrap.done", 16'(done_w), 16'h0000);
    step("load0100", 0, 0, 0, 16'h0100, 16'h0100, 0, 0, 0, 4'h0);
    step("borrow0100", 0, 1, 1, 16'h0000, 16'h0059, 0, 0, 1, 4'b0011);
    step("load1000", 0, 0, 0, 16'h1000, 16'h1000, 0, 0, 0, 4'h0);
    step("borrow1000", 0, 1, 1, 16'h0000, 16'h0959, 0, 0, 1, 4'b0111);
    step("load0001", 0, 0, 0, 16'h0001, 16'h0001, 0, 0, 0, 4'h0);
    step("to_zero", 0, 1, 1, 16'h0000, 16'h0000, 1, 1, 1, 4'b0000);
    step("stop_zero", 0, 1, 1, 16'h0000, 16'h0000, 1, 0, 1, 4'b1111);
    step("clampFA7C", 0, 0, 0, 16'hFA7C, 16'h5959, 0, 0, 0, 4'h0);
    step("load0000", 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 4'h0);
    step("load0230", 0, 0, 0, 16'h0230, 16'h0230, 0, 0, 0, 4'h0);
    step("clr_wins", 1, 0, 1, 16'h0230, 16'h0000, 1, 0, 0, 4'h0);
    step("load_wins", 0, 0, 1, 16'h0005, 16'h0005, 0, 0, 0, 4'h0);
    step("load0003", 0, 0, 0, 16'h0003, 16'h0003, 0, 0, 0, 4'h0);
    step("cnt2", 0, 1, 1, 16'h0000, 16'h0002, 0, 0, 0, 4'h0);
    step("pause1", 0, 1, 0, 16'h0000, 16'h0002, 0, 0, 1, 4'b0000);
    step("pause2", 0, 1, 0, 16'h0000, 16'h0002, 0, 0, 0, 4'h0);
    step("pause3", 0, 1, 0, 16'h0000, 16'h0002, 0, 0, 0, 4'h0);
    step("cnt1", 0, 1, 1, 16'h0000, 16'h0001, 0, 0, 0, 4'h0);
    step("cnt0", 0, 1, 1, 16'h0000, 16'h0000, 1, 1, 0, 4'h0);
    step("done_drop", 0, 1, 0, 16'h0000, 16'h0000, 1, 0, 1, 4'b0000);
    step("load0010", 0, 0, 0, 16'h0010, 16'h0010, 0, 0, 0, 4'h0);
    step("cnt0009", 0, 1, 1, 16'h0000, 16'h0009, 0, 0, 1, 4'b0001);
    step("clr_abort", 1, 1, 1, 16'h0000, 16'h0000, 1, 0, 0, 4'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
